// File: rtl/gnr_node_lut.sv
// Gene-regulatory-network node: a shared truth table drives N_CH state channels.
// Slow channels are divided by DIV; each channel tracks how many updates left it unchanged.
module gnr_node_lut #(
  parameter int                N_IN      = 2,
  parameter int                N_CH      = 2,
  parameter int                DIV       = 2,
  parameter logic [N_CH-1:0]   SLOW_MASK = N_CH'(1),
  parameter int                STABLE_TH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reset_nos,
  input  logic                   init_state,
  input  logic [N_CH-1:0]        start_ch,
  input  logic [N_CH*N_IN-1:0]   in_bits,
  input  logic                   lut_we,
  input  logic [(1<<N_IN)-1:0]   lut_data,
  output logic [N_CH-1:0]        s,
  output logic [N_CH-1:0]        changed,
  output logic [N_CH-1:0]        stable
);

  localparam int         LUT_W        = 1 << N_IN;
  localparam logic [3:0] PHASE_RELOAD = 4'(DIV - 1);
  localparam logic [7:0] STABLE_LIM   = 8'(STABLE_TH);

  logic [LUT_W-1:0]      lut_q, lut_d;
  logic [N_CH-1:0]       s_q, s_d;
  logic [N_CH-1:0]       changed_q, changed_d;
  logic [N_CH-1:0]       stable_q, stable_d;
  logic [N_CH-1:0][3:0]  phase_q, phase_d;
  logic [N_CH-1:0][7:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]       next_val;

  // Evaluation always reads the registered table, so a same-cycle load takes effect next cycle.
  always_comb begin
    next_val = '0;
    for (int i = 0; i < N_CH; i++) begin
      next_val[i] = lut_q[in_bits[i*N_IN +: N_IN]];
    end
  end

  always_comb begin
    lut_d     = lut_we ? lut_data : lut_q;
    s_d       = s_q;
    changed_d = '0;
    phase_d   = phase_q;
    cnt_d     = cnt_q;
    stable_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (reset_nos) begin
        s_d[i]     = init_state;
        phase_d[i] = 4'd0;
        cnt_d[i]   = 8'd0;
      end else if (start_ch[i]) begin
        if (phase_q[i] == 4'd0) begin
          s_d[i]       = next_val[i];
          changed_d[i] = (next_val[i] != s_q[i]);
          if (next_val[i] != s_q[i]) begin
            cnt_d[i] = 8'd0;
          end else if (cnt_q[i] != 8'hFF) begin
            cnt_d[i] = cnt_q[i] + 8'd1;
          end
          phase_d[i] = SLOW_MASK[i] ? PHASE_RELOAD : 4'd0;
        end else begin
          phase_d[i] = phase_q[i] - 4'd1;
        end
      end
      stable_d[i] = (cnt_d[i] >= STABLE_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lut_q     <= '0;
      s_q       <= '0;
      changed_q <= '0;
      stable_q  <= '0;
      phase_q   <= '0;
      cnt_q     <= '0;
    end else begin
      lut_q     <= lut_d;
      s_q       <= s_d;
      changed_q <= changed_d;
      stable_q  <= stable_d;
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
    end
  end

  assign s       = s_q;
  assign changed = changed_q;
  assign stable  = stable_q;

endmodule

// File: tb/tb_gnr_node_lut.sv
// Bench for gnr_node_lut: directed scenarios with literal expectations, then random
// traffic, all checked every cycle against a behavioural model of the channels.
module tb_gnr_node_lut;

  localparam int N_IN = 2;
  localparam int N_CH = 2;
  localparam int DIV  = 2;
  localparam int TH   = 4;
  localparam logic [N_CH-1:0] SLOW = 2'b01;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 reset_nos = 1'b0;
  logic                 init_state = 1'b0;
  logic [N_CH-1:0]      start_ch = '0;
  logic [N_CH*N_IN-1:0] in_bits = '0;
  logic                 lut_we = 1'b0;
  logic [3:0]           lut_data = '0;
  logic [N_CH-1:0]      s, changed, stable;

  int n_tests = 0;
  int n_fail  = 0;

  gnr_node_lut #(
    .N_IN(N_IN), .N_CH(N_CH), .DIV(DIV), .SLOW_MASK(SLOW), .STABLE_TH(TH)
  ) dut (
    .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
    .start_ch(start_ch), .in_bits(in_bits), .lut_we(lut_we), .lut_data(lut_data),
    .s(s), .changed(changed), .stable(stable)
  );

  always #5 clk = ~clk;

  // Behavioural model: table as a bit array, per-channel counters as plain ints.
  bit m_valid = 0;
  bit m_lut [4];
  bit m_s [N_CH];
  bit m_chg [N_CH];
  bit m_stb [N_CH];
  int m_skip [N_CH];
  int m_unchanged [N_CH];

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      for (int k = 0; k < 4; k++) m_lut[k] = 0;
      for (int c = 0; c < N_CH; c++) begin
        m_s[c] = 0; m_chg[c] = 0; m_stb[c] = 0; m_skip[c] = 0; m_unchanged[c] = 0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        int  idx;
        bit  nv;
        idx = int'(in_bits[c*N_IN +: N_IN]);
        nv  = m_lut[idx];
        m_chg[c] = 0;
        if (reset_nos) begin
          m_s[c] = init_state; m_skip[c] = 0; m_unchanged[c] = 0;
        end else if (start_ch[c]) begin
          if (m_skip[c] > 0) begin
            m_skip[c]--;
          end else begin
            m_chg[c] = (nv != m_s[c]);
            m_unchanged[c] = m_chg[c] ? 0 : ((m_unchanged[c] < 255) ? m_unchanged[c] + 1 : 255);
            m_s[c] = nv;
            m_skip[c] = SLOW[c] ? DIV - 1 : 0;
          end
        end
        m_stb[c] = (m_unchanged[c] >= TH);
      end
      if (lut_we) for (int k = 0; k < 4; k++) m_lut[k] = lut_data[k];
    end
  end

  // Single compare process against the model on every falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [N_CH-1:0] es, ec, eb;
      for (int c = 0; c < N_CH; c++) begin
        es[c] = m_s[c]; ec[c] = m_chg[c]; eb[c] = m_stb[c];
      end
      n_tests++;
      if (s !== es) begin
        n_fail++;
        $display("[TB] FAIL model_s at %0t: got %b expected %b", $time, s, es);
      end
      n_tests++;
      if (changed !== ec) begin
        n_fail++;
        $display("[TB] FAIL model_changed at %0t: got %b expected %b", $time, changed, ec);
      end
      n_tests++;
      if (stable !== eb) begin
        n_fail++;
        $display("[TB] FAIL model_stable at %0t: got %b expected %b", $time, stable, eb);
      end
    end
  end

  task automatic applyStimulus(input logic r, input logic rn, input logic init,
                               input logic [1:0] st, input logic [3:0] ib,
                               input logic we, input logic [3:0] ld);
    rst = r; reset_nos = rn; init_state = init; start_ch = st;
    in_bits = ib; lut_we = we; lut_data = ld;
    @(posedge clk);
    #1;
    rst = 1'b0; reset_nos = 1'b0; start_ch = '0; lut_we = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  initial begin
    // reset
    applyStimulus(1, 0, 0, 2'b00, 4'b0000, 0, 4'h0);
    applyStimulus(1, 0, 0, 2'b00, 4'b0000, 0, 4'h0);
    checkOutput("reset_s", s, 2'b00);
    checkOutput("reset_changed", changed, 2'b00);
    checkOutput("reset_stable", stable, 2'b00);

    // AND table, single start on ch1 with inputs 11
    applyStimulus(0, 1, 0, 2'b00, 4'b0000, 1, 4'b1000);
    applyStimulus(0, 0, 0, 2'b10, 4'b1100, 0, 4'h0);
    checkOutput("and_s", s, 2'b10);
    checkOutput("and_changed", changed, 2'b10);
    applyStimulus(0, 0, 0, 2'b00, 4'b1100, 0, 4'h0);
    checkOutput("and_changed_pulse", changed, 2'b00);

    // slow ch0 with DIV=2 updates on starts 1 and 3 only
    applyStimulus(0, 1, 0, 2'b00, 4'b0011, 0, 4'h0);
    applyStimulus(0, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("slow_start1", s, 2'b01);
    applyStimulus(0, 0, 0, 2'b01, 4'b0000, 0, 4'h0);
    checkOutput("slow_start2_skip", s, 2'b01);
    applyStimulus(0, 0, 0, 2'b01, 4'b0000, 0, 4'h0);
    checkOutput("slow_start3", s, 2'b00);
    checkOutput("slow_start3_changed", changed, 2'b01);
    applyStimulus(0, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("slow_start4_skip", s, 2'b00);

    // stable on fast ch1 after one changing and four unchanged updates
    applyStimulus(0, 1, 0, 2'b00, 4'b1100, 0, 4'h0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 0, 2'b10, 4'b1100, 0, 4'h0);
    checkOutput("stable_before", stable, 2'b00);
    applyStimulus(0, 0, 0, 2'b10, 4'b1100, 0, 4'h0);
    checkOutput("stable_after5", stable, 2'b10);

    // table load in the same cycle as a start uses the old table
    applyStimulus(0, 1, 0, 2'b00, 4'b0100, 0, 4'h0);
    applyStimulus(0, 0, 0, 2'b10, 4'b0100, 1, 4'b0111);
    checkOutput("lut_old", s, 2'b00);
    applyStimulus(0, 0, 0, 2'b10, 4'b0100, 0, 4'h0);
    checkOutput("lut_new", s, 2'b10);

    // reset_nos beats start; phase is zero so the next ch0 start updates
    applyStimulus(0, 1, 1, 2'b11, 4'b0000, 0, 4'h0);
    checkOutput("nos_over_start_s", s, 2'b11);
    checkOutput("nos_over_start_chg", changed, 2'b00);
    applyStimulus(0, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("nos_phase_zero", s, 2'b10);

    // rst while slow ch0 has phase 1, then first start updates immediately
    applyStimulus(0, 1, 0, 2'b00, 4'b0011, 1, 4'b1000);
    applyStimulus(0, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("pre_rst_s", s, 2'b01);
    applyStimulus(1, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("mid_rst_s", s, 2'b00);
    checkOutput("mid_rst_changed", changed, 2'b00);
    applyStimulus(0, 0, 0, 2'b00, 4'b0011, 1, 4'b1000);
    applyStimulus(0, 0, 0, 2'b01, 4'b0011, 0, 4'h0);
    checkOutput("post_rst_update", s, 2'b01);

    // random traffic against the model
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                    1'($urandom), 2'($urandom), 4'($urandom),
                    ($urandom_range(0, 7) == 0), 4'($urandom));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gnr_node_lut.md
GNR_NODE_LUT -- requirements
Module: gnr_node_lut

Interface
REQ-001 Parameter N_IN, default 2, number of regulator inputs per channel (legal 1..6).
REQ-002 Parameter N_CH, default 2, number of independent state channels (legal 1..8).
REQ-003 Parameter DIV, default 2, update divider for slow channels (legal 1..15; 1 = update on every start).
REQ-004 Parameter SLOW_MASK, default 1 (N_CH bits), where bit i=1 makes channel i a slow channel.
REQ-005 Parameter STABLE_TH, default 4, consecutive unchanged updates that assert stable (legal 1..255).
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 reset_nos  in  1  network re-initialisation strobe.
REQ-009 init_state  in  1  value loaded into every channel on reset_nos.
REQ-010 start_ch  in  N_CH  per-channel evaluation request, bit i for channel i.
REQ-011 in_bits  in  N_CH*N_IN  regulator states; channel i uses bits [i*N_IN +: N_IN].
REQ-012 lut_we  in  1  truth-table load strobe.
REQ-013 lut_data  in  2**N_IN  truth table; bit k is the next state for input pattern k.
REQ-014 s  out  N_CH  registered node state per channel.
REQ-015 changed  out  N_CH  one-cycle pulse per channel when an update changed the state.
REQ-016 stable  out  N_CH  per-channel level flag, asserted while unchanged-update count >= STABLE_TH.

Function
REQ-017 Next-state value for channel i SHALL be lut[in_bits slice i], using the slice as an unsigned index.
REQ-018 The truth table register SHALL load lut_data on any cycle with lut_we=1, regardless of reset_nos or start_ch.
REQ-019 An evaluation in the same cycle as lut_we SHALL use the old table; the new table SHALL apply from the next cycle.
REQ-020 Priority per channel SHALL be rst > reset_nos > start_ch.
REQ-021 reset_nos SHALL set s[i]=init_state, phase[i]=0, stable count[i]=0, and changed[i]=0 for all channels.
REQ-022 Fast channels (SLOW_MASK[i]=0) SHALL update s[i] on every cycle with start_ch[i]=1.
REQ-023 Slow channels SHALL carry a 4-bit phase counter.
REQ-024 For a slow channel, start_ch[i] with phase=0 SHALL update s[i] and load phase=DIV-1.
REQ-025 For a slow channel, start_ch[i] with phase>0 SHALL only decrement phase.
REQ-026 With DIV=2, a slow channel SHALL update on the 1st, 3rd, 5th... start after reset_nos.
REQ-027 With DIV=1, a slow channel SHALL behave identically to a fast channel.
REQ-028 Phase SHALL hold when start_ch[i]=0.
REQ-029 A performed update SHALL drive changed[i]=1 for exactly the next cycle if the new s[i] differs from the old s[i]; otherwise changed[i]=0.
REQ-030 A performed update with no change SHALL increment the 8-bit stable count[i], saturating at 255.
REQ-031 A performed update with a change SHALL clear stable count[i] to 0.
REQ-032 Skipped starts (phase>0) SHALL NOT affect the stable count.
REQ-033 stable[i] SHALL be registered, equal to (count[i] >= STABLE_TH), and valid in the cycle after the count update.
REQ-034 Update latency SHALL be one cycle: s reflects an evaluation in the cycle following start_ch.
REQ-035 Channels SHALL be fully independent; simultaneous starts on all channels SHALL all be serviced in the same cycle.

Reset
REQ-036 rst SHALL clear s, changed, stable, every phase counter, every stable count, and the truth table to 0 on the next rising edge.
REQ-037 rst asserted mid-operation SHALL abandon any divider phase, and the first start after release SHALL update slow channels.
REQ-038 No output SHALL be X after the first clock edge with rst=1.

Verification
REQ-039 Scenario: N_IN=2, lut_data=4'b1000 (AND), reset_nos with init_state=0, in_bits ch1=2'b11, one start_ch=2'b10 -> s=2'b10 next cycle, changed=2'b10 for one cycle.
REQ-040 Scenario: DIV=2 with slow ch0, in_bits ch0=2'b11, lut=AND, reset_nos (init 0), start_ch[0] on 4 consecutive cycles -> s[0]=1 after the 1st start, and updates occur only on starts 1 and 3 (observe by toggling inputs to 2'b00 before start 3).
REQ-041 Scenario: fast channel with constant inputs, STABLE_TH=4, 5 starts -> stable rises exactly one cycle after the 5th start (first update changes, next 4 do not).
REQ-042 Scenario: lut_we with lut_data=4'b0111 in the same cycle as start (old lut AND, inputs 2'b01) -> s stays 0; the next start gives s=1.
REQ-043 Scenario: reset_nos and start_ch asserted together with init_state=1 -> s=all 1, changed=0, phase=0.
REQ-044 Scenario: rst asserted while a slow channel has phase=1 -> all outputs 0, and after release reset_nos+start updates immediately.
